// File: rtl/fetch_sequencer.sv
// Purpose: instruction fetch sequencer; drives PC load/inc, reads program memory, holds the word for decode.
// Latency: FETCH -> WAIT -> HOLD, so instr_valid rises 2 cycles after FETCH; one instruction per 3 cycles.
// Backpressure: instr_valid/instr_ready handshake; HOLD is kept with instr stable until decode accepts.
//
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   pc_addr / pc_next           current PC in, branch load value out
//   pc_load / pc_inc            one-cycle PC control pulses (never both high)
//   imem_rd / imem_addr         program memory read strobe and address
//   imem_data                   read data, valid the cycle after imem_rd
//   instr / instr_valid         instruction register and its valid flag
//   instr_ready                 decode accepts instr this cycle
//   branch_req / branch_target  redirect fetch
//   halt / halted               stop after the accepted instruction; only RESET exits
module fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               pc_load,
    output logic               pc_inc,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_req,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic               halted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   valid_nxt;
    logic   capture;
    logic   handshake;
    logic   branch;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            instr_valid <= valid_nxt;
            // halted rises together with the move into HALTED and stays there
            halted      <= (state_nxt == HALTED);
            if (capture) begin
                instr <= imem_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = instr_valid;
        capture   = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_next   = '0;
        imem_rd   = 1'b0;
        imem_addr = '0;
        handshake = instr_valid & instr_ready;
        // branches are only honoured while actively fetching
        branch    = branch_req & ((state == FETCH) || (state == WAIT) || (state == HOLD));

        if (branch) begin
            pc_load = 1'b1;
            pc_next = branch_target;
        end

        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_rd   = 1'b1;
                imem_addr = pc_addr;
                state_nxt = branch ? FETCH : WAIT;
            end
            WAIT: begin
                if (branch) begin
                    // in-flight read is dropped; instr keeps its old value
                    state_nxt = FETCH;
                    valid_nxt = 1'b0;
                end else begin
                    capture   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (branch) begin
                    // a concurrent handshake still consumes the word, but the PC is redirected
                    state_nxt = FETCH;
                    valid_nxt = 1'b0;
                end else if (handshake) begin
                    valid_nxt = 1'b0;
                    if (halt) begin
                        state_nxt = HALTED;
                    end else begin
                        pc_inc    = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
